// File: rtl/tex_sram_arbiter.sv
// Arbitrates the texture SRAM: raster reads win, loader writes queue in a FIFO and drain on free cycles.
// Read data 1 cycle after rd_gnt; loader stalls on wr_ready=0 (FIFO full), starved writes forced after STARVE_LIMIT.

module tex_sram_arbiter_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_vld_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_dat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_vld_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign head_dat_o = mem_q[head_q];
  assign count_o    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_ok) tail_d = tail_q + PW'(1);
    if (pop_ok)  head_d = head_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= push_dat_i;
  end
endmodule

module tex_sram_arbiter #(
  parameter int AW           = 11,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_req,
  input  logic [AW-1:0]          rd_addr,
  output logic                   rd_gnt,
  output logic                   rd_valid,
  output logic [15:0]            rd_data,
  input  logic                   wr_valid,
  input  logic [AW-1:0]          wr_addr,
  input  logic                   wr_lane,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   idle,
  output logic                   sram_cen_n,
  output logic                   sram_wen_n,
  output logic [AW-1:0]          sram_addr,
  output logic                   sram_sel,
  output logic [7:0]             sram_din,
  input  logic [15:0]            sram_dout
);
  localparam int EW = AW + 9;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [EW-1:0] push_dat, head_dat;
  logic [AW-1:0] head_addr;
  logic          head_lane;
  logic [7:0]    head_data;
  logic          fifo_full, fifo_empty;
  logic          force_wr, wr_issue, push;
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_valid_q;

  assign push_dat = {wr_addr, wr_lane, wr_data};
  assign {head_addr, head_lane, head_data} = head_dat;
  assign wr_ready = !fifo_full;
  assign push     = wr_valid && wr_ready;

  tex_sram_arbiter_fifo #(.W(EW), .DEPTH(DEPTH)) u_wr_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_vld_i (push),
    .push_dat_i (push_dat),
    .pop_i      (wr_issue),
    .head_dat_o (head_dat),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    force_wr = (starve_q == SW'(STARVE_LIMIT)) && !fifo_empty;
    wr_issue = !fifo_empty && (!rd_req || force_wr);
    rd_gnt   = rd_req && !wr_issue;
  end

  always_comb begin
    sram_cen_n = 1'b1;
    sram_wen_n = 1'b1;
    sram_addr  = '0;
    sram_sel   = 1'b0;
    sram_din   = '0;
    if (wr_issue) begin
      sram_cen_n = 1'b0;
      sram_wen_n = 1'b0;
      sram_addr  = head_addr;
      sram_sel   = head_lane;
      sram_din   = head_data;
    end else if (rd_gnt) begin
      sram_cen_n = 1'b0;
      sram_addr  = rd_addr;
    end
  end

  // Counts cycles a queued write lost to a read; holds at the limit so the next cycle forces it.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || wr_issue)
      starve_d = '0;
    else if (rd_req && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      rd_valid_q <= rd_gnt;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = sram_dout;
  assign idle     = fifo_empty && !rd_req;
endmodule
